mult_div: RTL
=============

# mult_div

Multi-cycle signed multiply/divide unit on the datapath side of the control FSM. The control FSM issues a one-cycle `mult_start` or `div_start` and waits for `done`. The unit then writes the 64-bit product, or the quotient and remainder, into its HI/LO result registers, which feed the HI/LO datapath muxes. A divide by zero is reported back to the control FSM as `div_zero` so it can take the exception path.

## Interface
- Parameters: none. Data width is fixed at 32 bits.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `a` in 32: operand A (multiplicand / dividend), two's complement.
- `b` in 32: operand B (multiplier / divisor), two's complement.
- `mult_start` in 1: request a signed multiply; sampled only in IDLE.
- `div_start` in 1: request a signed divide; sampled only in IDLE.
- `hi` out 32: HI result register.
- `lo` out 32: LO result register.
- `done` out 1: one-cycle pulse; `hi`/`lo` hold the new result in this cycle.
- `busy` out 1: high while an operation is in progress.
- `div_zero` out 1: one-cycle pulse; divide requested with `b` == 0.

## Operation
- States and transitions:
  - IDLE: go to MULT on `mult_start`; otherwise go to DIV on `div_start`.
  - MULT and DIV: each runs 32 iterations, then goes to FINISH.
  - FINISH: lasts 1 cycle, then returns to IDLE.
  - DZERO: lasts 1 cycle, then returns to IDLE.
- Operand capture: `a` and `b` are latched on the edge that accepts a start. Later changes to the operand inputs have no effect on the running operation.
- Simultaneous `mult_start` and `div_start` in IDLE: multiply wins, divide request is dropped.
- Starts arriving in MULT, DIV, FINISH or DZERO are ignored, not queued.
- Multiply:
  - Radix-2 Booth, one bit per cycle.
  - 65-bit accumulator {P[63:0], q₋₁}; add/subtract uses a 33-bit sign-extended multiplicand, followed by an arithmetic shift.
  - Result: `hi` = product[63:32], `lo` = product[31:0]. The result is the exact signed 64-bit product.
- Divide:
  - Restoring division on operand magnitudes, one quotient bit per cycle.
  - Sign fix-up is applied on entry to FINISH:
    - quotient is negated if the signs of `a` and `b` differ (truncation toward zero);
    - remainder takes the sign of `a`.
  - Result: `lo` = quotient, `hi` = remainder.
  - 0x80000000 / 0xFFFFFFFF: `lo` = 0x80000000, `hi` = 0 (wraps; no flag raised).
- Divide by zero:
  - `div_start` with `b` == 0 goes to DZERO instead of DIV.
  - `div_zero` = 1 for that one cycle; `done` stays 0.
  - `hi` and `lo` are unchanged.
- Result registers: `hi`/`lo` update only on the edge entering FINISH. They hold their value otherwise, including across later starts, until the next completion.
- Reset:
  - At any time, including mid-operation: state = IDLE, `hi` = 0, `lo` = 0, `done` = 0, `busy` = 0, `div_zero` = 0.
  - The iteration counter and accumulators are cleared.
  - An aborted operation produces no `done`.

## Timing
- Cycle numbering: cycle 0 is the cycle in which a start is high in IDLE.
- Busy window: cycles 1..32 are MULT/DIV, with `busy` = 1.
- Completion: cycle 33 is FINISH, with `done` = 1, `busy` = 0, and `hi`/`lo` holding the new result.
- Back-to-back: cycle 34 is IDLE. The earliest next accepted start is in cycle 34, giving a 34-cycle issue interval.
- Divide by zero: cycle 1 is DZERO (`div_zero` = 1, `busy` = 0); cycle 2 is IDLE.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Multiply, mixed signs:** reset, then `mult_start` with a=7, b=0xFFFFFFFD (−3). Required: `done` only in cycle 33; `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB; `busy` high in cycles 1..32.
- **Multiply, extreme operands:** a=b=0x80000000. Required: `hi`=0x40000000, `lo`=0x00000000. Then a=0xFFFFFFFF, b=0x00000001. Required: `hi`=`lo`=0xFFFFFFFF.
- **Divide, signed cases:**
  - a=0xFFFFFFF9 (−7), b=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - a=7, b=0xFFFFFFFE → `lo`=0xFFFFFFFD, `hi`=1.
  - a=0x80000000, b=0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- **Divide by zero:** preload `hi`=0x12345678, `lo`=0x9ABCDEF0 via a multiply, then `div_start` with a=5, b=0. Required: `div_zero`=1 in cycle 1 only; no `done`; `hi`/`lo` unchanged; a new `mult_start` is accepted in cycle 2.
- **Arbitration and ignored starts:** `mult_start` and `div_start` both high with a=6, b=3. Required: product `hi`=0, `lo`=18. A `div_start` pulsed in cycle 10 changes nothing, and no second `done` follows.
- **Reset mid-operation:** assert `reset` in cycle 15 of a multiply. Required: next cycle `hi`=`lo`=0, `busy`=`done`=0, and no `done` pulse for the aborted operation. A fresh divide 100/7 then gives `lo`=14, `hi`=2 in its cycle 33.

Source files
------------

// File: rtl/mult_div.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring) unit
// writing a 64-bit product or quotient/remainder into HI/LO.
module mult_div (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mult_start,
  input  logic        div_start,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        done,
  output logic        busy,
  output logic        div_zero
);

  typedef enum logic [2:0] {IDLE, MULT, DIV, FINISH, DZERO} state_t;

  state_t      state, state_next;
  // Shared accumulator. Multiply: {A[31:0], Q[31:0], q_-1}.
  // Divide: {R[32:0], quotient[31:0]}.
  logic [64:0] acc;
  logic [64:0] mult_step, div_step;
  logic [31:0] mcand;
  logic [4:0]  cnt;
  logic        neg_q, neg_r;
  logic        last;
  logic [32:0] booth_sum, div_shift, div_trial;
  logic [31:0] a_mag, b_mag, q_fix, r_fix;

  always_comb begin
    a_mag = a[31] ? -a : a;
    b_mag = b[31] ? -b : b;
    last  = (cnt == 5'd31);

    case (acc[1:0])
      2'b01:   booth_sum = {acc[64], acc[64:33]} + {mcand[31], mcand};
      2'b10:   booth_sum = {acc[64], acc[64:33]} - {mcand[31], mcand};
      default: booth_sum = {acc[64], acc[64:33]};
    endcase
    // Arithmetic shift folded in: sum keeps its extra sign bit as the new A/Q boundary
    mult_step = {booth_sum, acc[32:1]};

    div_shift = {acc[63:32], acc[31]};
    div_trial = div_shift - {1'b0, mcand};
    div_step  = div_trial[32] ? {div_shift, acc[30:0], 1'b0}
                              : {div_trial, acc[30:0], 1'b1};
    q_fix = neg_q ? -div_step[31:0]  : div_step[31:0];
    r_fix = neg_r ? -div_step[63:32] : div_step[63:32];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (mult_start)     state_next = MULT;
        else if (div_start) state_next = (b == '0) ? DZERO : DIV;
      end
      MULT, DIV: if (last) state_next = FINISH;
      FINISH, DZERO: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      acc      <= '0;
      mcand    <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state    <= state_next;
      done     <= (state_next == FINISH);
      busy     <= (state_next == MULT) || (state_next == DIV);
      div_zero <= (state_next == DZERO);
      case (state)
        IDLE: begin
          cnt <= '0;
          if (mult_start) begin
            acc   <= {32'b0, b, 1'b0};
            mcand <= a;
          end else if (div_start) begin
            acc   <= {33'b0, a_mag};
            mcand <= b_mag;
            neg_q <= a[31] ^ b[31];
            neg_r <= a[31];
          end
        end
        MULT: begin
          acc <= mult_step;
          cnt <= cnt + 5'd1;
          if (last) {hi, lo} <= mult_step[64:1];
        end
        DIV: begin
          acc <= div_step;
          cnt <= cnt + 5'd1;
          if (last) begin
            lo <= q_fix;
            hi <= r_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
